// File: rtl/dt_sti_unpack_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | dt_sti_unpack_ctrl : unpacks 16-pixel sti ROM words into one byte per pixel |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module dt_sti_unpack_ctrl #(
    parameter int         WORDS     = 1024,
    parameter bit         ZERO_SKIP = 1'b0,
    parameter logic [7:0] FG_VALUE  = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        load_done,
    output logic        sti_rd,
    output logic [9:0]  sti_addr,
    input  logic [15:0] sti_di,
    output logic        res_wr,
    output logic [13:0] res_addr,
    output logic [7:0]  res_do,
    output logic [14:0] fg_count
);

    localparam logic [9:0] LAST_W = 10'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  w_q, w_d;
    logic [3:0]  k_q, k_d;
    logic [15:0] sh_q, sh_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [7:0]  do_q, do_d;
    logic [14:0] fg_q, fg_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            k_q     <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            do_q    <= '0;
            fg_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            do_q    <= do_d;
            fg_q    <= fg_d;
        end
    end

    // Outputs are registered: each transition computes what the next cycle shows.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        k_d     = k_q;
        sh_d    = sh_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        do_d    = do_q;
        fg_d    = fg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    done_d  = 1'b0;
                    fg_d    = '0;
                    w_d     = '0;
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                end
            end
            FETCH: begin
                // Pixel 0 goes out immediately, so the register keeps only the remaining 15.
                k_d  = '0;
                sh_d = {sti_di[14:0], 1'b0};
                if (ZERO_SKIP && (sti_di == 16'h0000)) begin
                    if (w_q == LAST_W) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        w_d  = w_q + 10'd1;
                        rd_d = 1'b1;
                    end
                end else begin
                    state_d = WRITE;
                    wr_d    = !ZERO_SKIP || sti_di[15];
                    do_d    = sti_di[15] ? FG_VALUE : 8'h00;
                    fg_d    = fg_q + {14'd0, sti_di[15]};
                end
            end
            WRITE: begin
                if (k_q == 4'd15) begin
                    if (w_q == LAST_W) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        w_d     = w_q + 10'd1;
                        rd_d    = 1'b1;
                    end
                end else begin
                    k_d  = k_q + 4'd1;
                    sh_d = {sh_q[14:0], 1'b0};
                    wr_d = !ZERO_SKIP || sh_q[15];
                    do_d = sh_q[15] ? FG_VALUE : 8'h00;
                    fg_d = fg_q + {14'd0, sh_q[15]};
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign load_done = done_q;
    assign sti_rd    = rd_q;
    assign sti_addr  = w_q;
    assign res_wr    = wr_q;
    assign res_addr  = {w_q, k_q};
    assign res_do    = do_q;
    assign fg_count  = fg_q;

endmodule
`default_nettype wire

// File: tb/tb_dt_sti_unpack_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_dt_sti_unpack_ctrl : directed self-checking bench for dt_sti_unpack_ctrl |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_dt_sti_unpack_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start_z = 1'b0;
    always #5 clk = ~clk;

    logic        busy, load_done, sti_rd, res_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di = '0;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic [14:0] fg_count;

    logic        busy_z, load_done_z, sti_rd_z, res_wr_z;
    logic [9:0]  sti_addr_z;
    logic [15:0] sti_di_z = '0;
    logic [13:0] res_addr_z;
    logic [7:0]  res_do_z;
    logic [14:0] fg_count_z;

    dt_sti_unpack_ctrl #(.WORDS(1024), .ZERO_SKIP(1'b0), .FG_VALUE(8'h01)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .load_done(load_done),
        .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di), .res_wr(res_wr),
        .res_addr(res_addr), .res_do(res_do), .fg_count(fg_count)
    );

    dt_sti_unpack_ctrl #(.WORDS(1024), .ZERO_SKIP(1'b1), .FG_VALUE(8'h01)) dut_z (
        .clk(clk), .reset(reset), .start(start_z), .busy(busy_z), .load_done(load_done_z),
        .sti_rd(sti_rd_z), .sti_addr(sti_addr_z), .sti_di(sti_di_z), .res_wr(res_wr_z),
        .res_addr(res_addr_z), .res_do(res_do_z), .fg_count(fg_count_z)
    );

    logic [15:0] sti_mem [1024];
    logic [15:0] sti_zs  [1024];
    logic [7:0]  res_mem [16384];
    logic [7:0]  res_zs  [16384];

    int          wr_cnt = 0;
    int          wr_cnt_z = 0;
    logic [13:0] last_addr_z = '0;
    logic [7:0]  last_do_z = '0;
    int          overlap = 0;
    int          ld_rises = 0;
    logic        ld_prev = 1'b0;

    // ROM models update on the falling edge; RAM models write on the rising edge.
    always @(negedge clk) begin
        if (sti_rd)   sti_di   <= sti_mem[sti_addr];
        if (sti_rd_z) sti_di_z <= sti_zs[sti_addr_z];
    end

    always @(posedge clk) begin
        if (res_wr) begin
            res_mem[res_addr] <= res_do;
            wr_cnt <= wr_cnt + 1;
        end
        if (res_wr_z) begin
            res_zs[res_addr_z] <= res_do_z;
            wr_cnt_z    <= wr_cnt_z + 1;
            last_addr_z <= res_addr_z;
            last_do_z   <= res_do_z;
        end
    end

    always @(negedge clk) begin
        if ((sti_rd && res_wr) || (sti_rd_z && res_wr_z)) overlap <= overlap + 1;
        if (load_done && !ld_prev) ld_rises <= ld_rises + 1;
        ld_prev <= load_done;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ram_mismatches();
        int m = 0;
        for (int p = 0; p < 16384; p++) begin
            logic [15:0] wd;
            logic        b;
            wd = sti_mem[p / 16];
            b  = wd[15 - (p % 16)];
            if (res_mem[p] !== (b ? 8'h01 : 8'h00)) m++;
        end
        return m;
    endfunction

    function automatic int popcount_image();
        int pc = 0;
        for (int i = 0; i < 1024; i++) pc += $countones(sti_mem[i]);
        return pc;
    endfunction

    // Counts cycles from the first FETCH through the FIN cycle; optionally
    // pokes start once mid-load and once during FIN.
    task automatic wait_load(input bit poke, output int cyc);
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (sti_rd) seen = 1'b1;
            if (seen) cyc++;
            start = (poke && cyc == 100);
            if (load_done) begin
                if (poke) start = 1'b1;
                break;
            end
        end
        chk("load_done_seen", {31'd0, load_done}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int wc;
        bit seen;

        for (int i = 0; i < 1024; i++) begin
            sti_mem[i] = '0;
            sti_zs[i]  = '0;
        end
        for (int i = 0; i < 16384; i++) begin
            res_mem[i] = 8'hAA;
            res_zs[i]  = 8'h00;
        end

        // Power-up reset
        repeat (3) @(negedge clk);
        chk("rst_ctl",  {28'd0, busy, load_done, sti_rd, res_wr}, 32'd0);
        chk("rst_addr", {8'd0, sti_addr, res_addr}, 32'd0);
        chk("rst_data", {9'd0, res_do, fg_count}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // ZERO_SKIP instance: only the last word has a set bit
        sti_zs[1023] = 16'h0001;
        start_z = 1'b1;
        cyc = 0;
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start_z = 1'b0;
            if (sti_rd_z) seen = 1'b1;
            if (seen) cyc++;
            if (load_done_z) break;
        end
        chk("zs_done",    {31'd0, load_done_z}, 32'd1);
        chk("zs_cycles",  cyc, 32'd1041);
        chk("zs_wr_cnt",  wr_cnt_z, 32'd1);
        chk("zs_wr_addr", {18'd0, last_addr_z}, 32'd16383);
        chk("zs_wr_data", {24'd0, last_do_z}, 32'd1);
        chk("zs_fg",      {17'd0, fg_count_z}, 32'd1);
        chk("zs_ram_end", {24'd0, res_zs[16383]}, 32'd1);

        // Word 0 = 8001, rest zero
        sti_mem[0] = 16'h8001;
        @(negedge clk);
        start = 1'b1;
        wait_load(1'b0, cyc);
        chk("t1_cycles", cyc, 32'd17409);
        chk("t1_fg",     {17'd0, fg_count}, 32'd2);
        chk("t1_ram0",   {24'd0, res_mem[0]}, 32'd1);
        chk("t1_ram15",  {24'd0, res_mem[15]}, 32'd1);
        chk("t1_ram1",   {24'd0, res_mem[1]}, 32'd0);
        chk("t1_ram16",  {24'd0, res_mem[16]}, 32'd0);
        chk("t1_ram_all", ram_mismatches(), 32'd0);

        // All FFFF, with start pulsed mid-load and during FIN
        for (int i = 0; i < 1024; i++) sti_mem[i] = 16'hFFFF;
        ld_rises = 0;
        @(negedge clk);
        start = 1'b1;
        wait_load(1'b1, cyc);
        repeat (5) @(negedge clk);
        chk("t2_cycles",  cyc, 32'd17409);
        chk("t2_idle",    {30'd0, busy, sti_rd}, 32'd0);
        chk("t2_ld_rises", ld_rises, 32'd1);
        chk("t2_ld_held", {31'd0, load_done}, 32'd1);
        chk("t2_fg",      {17'd0, fg_count}, 32'd16384);
        chk("t2_ram_all", ram_mismatches(), 32'd0);

        // Scrambled image; third start clears status, then reset mid word 500
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] x;
            x = (i + 1) * 32'h9E3779B1;
            sti_mem[i] = x[31:16] ^ x[15:0];
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3_clear", {15'd0, load_done, fg_count, busy}, 32'd1);
        for (int n = 0; n < 10000; n++) begin
            if (res_wr && res_addr == 14'd8008) break;
            @(negedge clk);
        end
        chk("t3_mid_reached", {18'd0, res_addr}, 32'd8008);
        reset = 1'b0;
        #1;
        chk("t3_rst_ctl",  {28'd0, busy, load_done, sti_rd, res_wr}, 32'd0);
        chk("t3_rst_addr", {8'd0, sti_addr, res_addr}, 32'd0);
        chk("t3_rst_data", {9'd0, res_do, fg_count}, 32'd0);
        wc = wr_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("t3_no_writes", wr_cnt - wc, 32'd0);
        chk("t3_no_done",   {29'd0, busy, load_done, sti_rd}, 32'd0);

        // Reload from word 0
        start = 1'b1;
        wait_load(1'b0, cyc);
        chk("t4_cycles",  cyc, 32'd17409);
        chk("t4_fg",      {17'd0, fg_count}, popcount_image());
        chk("t4_ram_all", ram_mismatches(), 32'd0);
        chk("t4_last_addr", {18'd0, res_addr}, 32'd16383);
        chk("no_rd_wr_overlap", overlap, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
